// File: rtl/evm_pkg.sv
// evm_pkg: session state encoding and port-width helpers for the voting controller
package evm_pkg;
  typedef enum logic [1:0] {CLOSED, IDLE, VERIFY, VOTE} evm_state_e;
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int opw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/evm_sat_counter.sv
// evm_sat_counter: clearable up-counter that holds at its maximum value
module evm_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && ~&count_q) ? count_q + CNT_W'(1) : count_q;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/evm_tally_ctrl.sv
// evm_tally_ctrl: election session FSM with duplicate-vote protection, vote timeout and per-candidate tallies
module evm_tally_ctrl
  import evm_pkg::*;
#(
  parameter int NUM_VOTERS   = 8,
  parameter int NUM_CANDS    = 4,
  parameter int CNT_W        = 8,
  parameter int VOTE_TIMEOUT = 16,
  localparam int IDW = idw(NUM_VOTERS),
  localparam int OPW = opw(NUM_CANDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             open_i,
  input  logic             close_i,
  input  logic             id_valid,
  input  logic [IDW-1:0]   id,
  input  logic             vote_valid,
  input  logic [OPW-1:0]   option,
  output logic             verified,
  output logic             not_verified,
  output logic             vote_lock,
  output logic             vote_reject,
  output logic             timeout,
  output logic             busy,
  output logic             election_open,
  input  logic [OPW-1:0]   rd_sel,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] total_votes
);
  localparam int TW = idw(VOTE_TIMEOUT);
  localparam int NID = 2 ** IDW;
  localparam int NOP = 2 ** OPW;
  localparam logic [IDW:0] NV = (IDW + 1)'(NUM_VOTERS);
  localparam logic [OPW:0] NC = (OPW + 1)'(NUM_CANDS);
  localparam logic [TW-1:0] TMAX = TW'(VOTE_TIMEOUT - 1);

  evm_state_e state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [NID-1:0] voted_q, voted_d;
  // {verified, not_verified, vote_lock, vote_reject, timeout}
  logic [4:0] pulse_q, pulse_d;
  logic commit, clr, id_ok, opt_ok;
  logic [CNT_W-1:0] tally [NOP];

  always_comb begin
    state_d = state_q;
    id_d = id_q;
    timer_d = '0;
    voted_d = voted_q;
    pulse_d = '0;
    commit = 1'b0;
    clr = 1'b0;
    id_ok = ({1'b0, id_q} < NV) && !voted_q[id_q];
    opt_ok = {1'b0, option} < NC;
    case (state_q)
      CLOSED: if (open_i) begin
        state_d = IDLE;
        voted_d = '0;
        clr = 1'b1;
      end
      IDLE: if (id_valid) begin
        state_d = VERIFY;
        id_d = id;
      end
      VERIFY: begin
        state_d = id_ok ? VOTE : IDLE;
        pulse_d[4:3] = {id_ok, !id_ok};
      end
      VOTE: if (vote_valid && opt_ok) begin
        commit = 1'b1;
        voted_d[id_q] = 1'b1;
        pulse_d[2] = 1'b1;
        state_d = IDLE;
      end else begin
        pulse_d[1] = vote_valid;
        pulse_d[0] = timer_q == TMAX;
        state_d = (timer_q == TMAX) ? IDLE : VOTE;
        timer_d = (timer_q == TMAX) ? '0 : timer_q + TW'(1);
      end
    endcase
    // closing drops any in-flight session but keeps tallies for readout
    if (close_i) begin
      state_d = CLOSED;
      voted_d = voted_q;
      pulse_d = '0;
      commit = 1'b0;
      clr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLOSED;
      id_q <= '0;
      timer_q <= '0;
      voted_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      timer_q <= timer_d;
      voted_q <= voted_d;
      pulse_q <= pulse_d;
    end
  end

  for (genvar c = 0; c < NOP; c++) begin : g_tally
    if (c < NUM_CANDS) begin : g_cnt
      evm_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk), .reset(reset), .clr(clr), .inc(commit && option == OPW'(c)), .count(tally[c])
      );
    end else begin : g_pad
      assign tally[c] = '0;
    end
  end

  evm_sat_counter #(.CNT_W(CNT_W)) u_total (
    .clk(clk), .reset(reset), .clr(clr), .inc(commit), .count(total_votes)
  );

  assign {verified, not_verified, vote_lock, vote_reject, timeout} = pulse_q;
  assign busy = state_q == VERIFY || state_q == VOTE;
  assign election_open = state_q != CLOSED;
  assign rd_count = tally[rd_sel];
endmodule

// File: tb/tb_evm_tally_ctrl.sv
// tb_evm_tally_ctrl: directed table, corner sequences and randomized sessions against a ballot-level model
module tb_evm_tally_ctrl;
  localparam int NV = 6, NC = 3, CW = 2, VT = 16;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0, reset = 1'b1, open_i = 1'b0, close_i = 1'b0;
  logic id_valid = 1'b0, vote_valid = 1'b0;
  logic [2:0] id = '0;
  logic [1:0] option = '0, rd_sel = '0;
  logic verified, not_verified, vote_lock, vote_reject, timeout, busy, election_open;
  logic [CW-1:0] rd_count, total_votes;

  int n_chk = 0, n_pass = 0;
  bit m_open;
  bit m_voted [8];
  int m_tally [4];
  int m_total;

  typedef struct {int id; int wt; int opt; bit ev; bit lk; int sel; int cnt; int tot;} vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  evm_tally_ctrl #(.NUM_VOTERS(NV), .NUM_CANDS(NC), .CNT_W(CW), .VOTE_TIMEOUT(VT)) dut (
    .clk(clk), .reset(reset), .open_i(open_i), .close_i(close_i),
    .id_valid(id_valid), .id(id), .vote_valid(vote_valid), .option(option),
    .verified(verified), .not_verified(not_verified), .vote_lock(vote_lock),
    .vote_reject(vote_reject), .timeout(timeout), .busy(busy), .election_open(election_open),
    .rd_sel(rd_sel), .rd_count(rd_count), .total_votes(total_votes)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic present_id(input int i);
    id_valid = 1'b1;
    id = 3'(i);
    step();
    id_valid = 1'b0;
    step();
  endtask

  task automatic cast(input int o);
    vote_valid = 1'b1;
    option = 2'(o);
    step();
    vote_valid = 1'b0;
  endtask

  task automatic chk_tally(input string nm, input int sel, input int exp);
    rd_sel = 2'(sel);
    #1;
    chk(nm, int'(rd_count), exp);
  endtask

  task automatic wait_timeout();
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < VT + 4) begin
      step();
      n++;
      seen = timeout;
    end
    chk("timeout_cycles", seen ? n : -1, VT);
  endtask

  function automatic int sat_inc(input int v);
    return (v < SAT) ? v + 1 : v;
  endfunction

  initial begin
    int r, i, wt, o, sel;
    bit ev;
    tbl[0] = '{3, 0, 2, 1, 1, 2, 1, 1};
    tbl[1] = '{3, 0, 2, 0, 0, 2, 1, 1};
    tbl[2] = '{5, 0, -1, 1, 0, 0, 0, 1};
    tbl[3] = '{5, 3, 0, 1, 1, 0, 1, 2};
    tbl[4] = '{7, 0, 0, 0, 0, 0, 1, 2};
    tbl[5] = '{0, 15, 1, 1, 1, 1, 1, 3};
    tbl[6] = '{1, 0, 1, 1, 1, 1, 2, 3};

    idle(2);
    chk("rst_open", int'(election_open), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({verified, not_verified, vote_lock, vote_reject, timeout}), 0);
    chk("rst_total", int'(total_votes), 0);
    chk_tally("rst_tally", 0, 0);
    reset = 1'b0;
    present_id(2);
    chk("closed_ignores_id", int'(verified | not_verified), 0);
    open_i = 1'b1;
    step();
    open_i = 1'b0;
    chk("open", int'(election_open), 1);

    foreach (tbl[k]) begin
      present_id(tbl[k].id);
      chk($sformatf("t%0d_verified", k), int'(verified), int'(tbl[k].ev));
      chk($sformatf("t%0d_not_verified", k), int'(not_verified), int'(!tbl[k].ev));
      if (tbl[k].ev) begin
        if (tbl[k].opt < 0) wait_timeout();
        else begin
          idle(tbl[k].wt);
          cast(tbl[k].opt);
          chk($sformatf("t%0d_lock", k), int'(vote_lock), int'(tbl[k].lk));
        end
      end
      chk_tally($sformatf("t%0d_tally", k), tbl[k].sel, tbl[k].cnt);
      chk($sformatf("t%0d_total", k), int'(total_votes), tbl[k].tot);
    end

    present_id(2);
    chk("rej_busy", int'(busy), 1);
    step();
    chk("verified_one_cycle", int'(verified), 0);
    cast(3);
    chk("rej_pulse", int'(vote_reject), 1);
    chk("rej_no_lock", int'(vote_lock), 0);
    chk("rej_still_busy", int'(busy), 1);
    step();
    chk("rej_one_cycle", int'(vote_reject), 0);
    cast(1);
    chk("rej_then_lock", int'(vote_lock), 1);
    chk_tally("rej_tally1_sat", 1, 3);
    chk_tally("rd_sel_oob", 3, 0);

    present_id(4);
    close_i = 1'b1;
    vote_valid = 1'b1;
    option = 2'd0;
    step();
    close_i = 1'b0;
    vote_valid = 1'b0;
    chk("close_open", int'(election_open), 0);
    chk("close_no_lock", int'(vote_lock), 0);
    chk("close_busy", int'(busy), 0);
    chk_tally("close_keep0", 0, 1);
    chk_tally("close_keep1", 1, 3);
    cast(0);
    chk("closed_ignores_vote", int'(total_votes), 3);
    open_i = 1'b1;
    step();
    open_i = 1'b0;
    chk("reopen", int'(election_open), 1);
    for (int c = 0; c < NC; c++) chk_tally($sformatf("reopen_clr%0d", c), c, 0);
    chk("reopen_total", int'(total_votes), 0);

    present_id(3);
    chk("revote_accepted", int'(verified), 1);
    cast(0);
    for (int v = 0; v < 3; v++) begin
      present_id(v);
      cast(0);
      chk($sformatf("sat_lock%0d", v), int'(vote_lock), 1);
    end
    chk_tally("sat_tally0", 0, 3);
    chk("sat_total", int'(total_votes), 3);
    for (int v = 0; v < 4; v++) begin
      present_id(v);
      chk($sformatf("sat_marked%0d", v), int'(not_verified), 1);
    end

    open_i = 1'b1;
    step();
    open_i = 1'b0;
    chk_tally("open_while_open", 0, 3);
    open_i = 1'b1;
    close_i = 1'b1;
    step();
    chk("open_close_open", int'(election_open), 0);
    step();
    open_i = 1'b0;
    close_i = 1'b0;
    chk("open_close_closed", int'(election_open), 0);
    chk_tally("open_close_keep", 0, 3);

    open_i = 1'b1;
    step();
    open_i = 1'b0;
    present_id(4);
    reset = 1'b1;
    vote_valid = 1'b1;
    option = 2'd0;
    step();
    reset = 1'b0;
    vote_valid = 1'b0;
    chk("midrst_no_lock", int'(vote_lock), 0);
    chk("midrst_open", int'(election_open), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_total", int'(total_votes), 0);

    m_open = 0;
    m_total = 0;
    foreach (m_voted[k]) m_voted[k] = 0;
    foreach (m_tally[k]) m_tally[k] = 0;
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 19);
      if (!m_open || r == 0) begin
        if (m_open) begin
          close_i = 1'b1;
          step();
          close_i = 1'b0;
          m_open = 0;
        end else begin
          open_i = 1'b1;
          step();
          open_i = 1'b0;
          m_open = 1;
          m_total = 0;
          foreach (m_voted[k]) m_voted[k] = 0;
          foreach (m_tally[k]) m_tally[k] = 0;
        end
        chk("rnd_open", int'(election_open), int'(m_open));
      end else begin
        i = $urandom_range(0, 7);
        ev = i < NV && !m_voted[i];
        present_id(i);
        chk("rnd_verified", int'(verified), int'(ev));
        chk("rnd_not_verified", int'(not_verified), int'(!ev));
        if (ev) begin
          wt = $urandom_range(0, 17);
          o = $urandom_range(0, 3);
          if (r == 1) begin
            idle(wt % 8);
            close_i = 1'b1;
            vote_valid = 1'b1;
            option = 2'(o);
            step();
            close_i = 1'b0;
            vote_valid = 1'b0;
            m_open = 0;
            chk("rnd_close_no_lock", int'(vote_lock), 0);
          end else if (wt >= VT) begin
            idle(VT - 1);
            chk("rnd_no_early_timeout", int'(timeout), 0);
            step();
            chk("rnd_timeout", int'(timeout), 1);
          end else begin
            idle(wt);
            cast(o);
            if (o < NC) begin
              chk("rnd_lock", int'(vote_lock), 1);
              m_voted[i] = 1;
              m_tally[o] = sat_inc(m_tally[o]);
              m_total = sat_inc(m_total);
            end else begin
              chk("rnd_reject", int'(vote_reject), 1);
              chk("rnd_reject_timeout", int'(timeout), int'(wt == VT - 1));
              if (wt < VT - 1) begin
                o = $urandom_range(0, NC - 1);
                cast(o);
                chk("rnd_lock_after_reject", int'(vote_lock), 1);
                m_voted[i] = 1;
                m_tally[o] = sat_inc(m_tally[o]);
                m_total = sat_inc(m_total);
              end
            end
          end
        end
        sel = $urandom_range(0, 3);
        chk_tally("rnd_tally", sel, (sel < NC) ? m_tally[sel] : 0);
        chk("rnd_total", int'(total_votes), m_total);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/evm_tally_ctrl.md
Name: evm_tally_ctrl

Overview:
Parametrised electronic voting controller with per-voter duplicate-vote protection, per-candidate tally counters, a vote timeout and open/close election control. The block sits between the voter ID/ballot front-end and the results display logic. Tallies can be read at any time through a mux port.

Parameters:
NUM_VOTERS, 8, number of registered voters; ID range 0..NUM_VOTERS-1
NUM_CANDS, 4, number of candidates; option range 0..NUM_CANDS-1
CNT_W, 8, width of each tally counter and of the total counter
VOTE_TIMEOUT, 16, cycles allowed in VOTE before the session is abandoned (>=2)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
open_i  in  1  pulse: open election (CLOSED -> IDLE)
close_i  in  1  pulse: close election (any state -> CLOSED)
id_valid  in  1  voter ID presented
id  in  IDW=max(1,$clog2(NUM_VOTERS))  voter ID
vote_valid  in  1  ballot presented
option  in  OPW=max(1,$clog2(NUM_CANDS))  chosen candidate
verified  out  1  1-cycle pulse: voter accepted
not_verified  out  1  1-cycle pulse: voter rejected
vote_lock  out  1  1-cycle pulse: vote committed
vote_reject  out  1  1-cycle pulse: invalid option ignored
timeout  out  1  1-cycle pulse: session abandoned
busy  out  1  high in VERIFY/VOTE
election_open  out  1  high when not CLOSED
rd_sel  in  OPW  candidate select for readout
rd_count  out  CNT_W  tally[rd_sel], combinational; 0 if rd_sel>=NUM_CANDS
total_votes  out  CNT_W  committed vote count

Behaviour:
- Reset: state=CLOSED; all pulse outputs 0; busy=0; election_open=0; voted bitmap, all tallies, total_votes and timer = 0.
- All pulse outputs are registered and high for exactly one cycle.
- CLOSED: ignores id_valid/vote_valid. open_i -> IDLE; also clears bitmap, tallies and total (new election).
- IDLE: on id_valid, capture id -> VERIFY (next cycle).
- VERIFY (1 cycle): if id>=NUM_VOTERS or voted[id]=1 -> not_verified pulse, -> IDLE. Else -> verified pulse, timer=0, -> VOTE. The bitmap is NOT set here.
- VOTE: on vote_valid with option<NUM_CANDS: tally[option]+=1 (saturate at 2^CNT_W-1), total_votes+=1 (saturate), voted[id]=1, vote_lock pulse, -> IDLE. On vote_valid with option>=NUM_CANDS: vote_reject pulse, stay in VOTE, timer continues. If the timer reaches VOTE_TIMEOUT-1 with no valid commit: timeout pulse, -> IDLE, voter remains eligible.
- Latency: id_valid sampled at edge N -> verified/not_verified visible after edge N+1. vote_valid sampled at edge M -> vote_lock and updated rd_count/total visible after edge M.
- close_i has priority over every other input in every state: -> CLOSED next cycle. An in-flight session is dropped with no vote_lock and no bitmap update. Tallies are retained for readout.
- Simultaneous open_i and close_i: close wins.
- open_i while not CLOSED: ignored (no clear).
- id_valid outside IDLE is ignored. vote_valid outside VOTE is ignored.
- Reset mid-session: everything clears, with no pulses on the reset cycle.
- Counter saturation holds the value; saturating one counter does not block total_votes or the bitmap update.

Decomposition:
- Package evm_pkg: state enum (CLOSED, IDLE, VERIFY, VOTE) as a 2-bit typedef, plus the IDW/OPW width helper functions.
- One sub-module, evm_sat_counter (CNT_W param; inputs inc and clr; output count; saturating). It is instantiated NUM_CANDS times for the tallies and once for total_votes.

Test Plan:
- Open, id=3, vote option=2 -> verified 1 cycle after id_valid, vote_lock pulse, rd_sel=2 gives rd_count=1, total_votes=1.
- Same id=3 again -> not_verified pulse, no tally change.
- id=5, no vote_valid for 16 cycles -> timeout pulse. id=5 retried, then vote 0 -> vote_lock, tally[0]=1.
- NUM_CANDS=3, option=3 in VOTE -> vote_reject, still busy. Then option=1 -> vote_lock, tally[1]=1.
- CNT_W=2: four votes for candidate 0 from distinct IDs -> rd_count stays at 3, total_votes=3, all four IDs marked voted.
- close_i during VOTE -> election_open=0, no vote_lock, tallies retained. open_i -> all tallies 0, and the previously voted id is accepted again.
